// File: rtl/scalar_hazard_ctrl.sv
// Hazard and sequencing controller for the scalar pipeline.
// Produces same-cycle stall/flush controls for PC, IF/ID, ID/EX and EX/WB
// from load-use, taken-branch and multi-cycle execute hazards. A watchdog
// aborts a hung multi-cycle op. Saturating perf counters are kept for debug.
module scalar_hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int ZERO_REG   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_rs1_addr,
  input  logic [3:0]  id_rs2_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        ex_valid,
  input  logic [3:0]  ex_rd_addr,
  input  logic        ex_we,
  input  logic        ex_is_load,
  input  logic        ex_mc_start,
  input  logic        ex_mc_done,
  input  logic        ex_branch_taken,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_wb_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_wb_flush,
  output logic        mc_timeout,
  output logic        protocol_err,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_events
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MC_WAIT  = 2'd1,
    MC_ABORT = 2'd2
  } state_t;

  // Last watchdog value before the hung op is aborted.
  localparam logic [7:0] WDOG_LAST = 8'(MC_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        mc_timeout_q, mc_timeout_d;
  logic        protocol_err_q, protocol_err_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_events_q, flush_events_d;

  logic pc_stall_c, if_id_stall_c, id_ex_stall_c;
  logic if_id_flush_c, id_ex_flush_c, ex_wb_flush_c;
  logic flush_inc;
  logic mc_begin, branch_hit, rd_nonzero, src_match, load_use_hit;

  // Hazard detection terms evaluated against the current EX/ID contents.
  always_comb begin
    mc_begin     = ex_valid && ex_mc_start && !ex_mc_done;
    branch_hit   = ex_valid && ex_branch_taken;
    rd_nonzero   = (ZERO_REG == 0) || (ex_rd_addr != 4'd0);
    src_match    = (id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                   (id_rs2_used && (id_rs2_addr == ex_rd_addr));
    load_use_hit = ex_valid && ex_is_load && ex_we && rd_nonzero &&
                   id_valid && src_match;
  end

  // Next-state, watchdog and same-cycle stall/flush decisions.
  always_comb begin
    state_d        = state_q;
    wdog_d         = wdog_q;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_wb_flush_c  = 1'b0;
    mc_timeout_d   = 1'b0;
    protocol_err_d = 1'b0;
    flush_inc      = 1'b0;
    case (state_q)
      IDLE: begin
        wdog_d = 8'd0;
        if ((ex_mc_start && ex_branch_taken) || (ex_mc_done && !ex_mc_start))
          protocol_err_d = 1'b1;
        if (mc_begin) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_stall_c = 1'b1;
          ex_wb_flush_c = 1'b1;
          state_d       = MC_WAIT;
          wdog_d        = 8'd1;
        end else if (branch_hit) begin
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
          flush_inc     = 1'b1;
        end else if (load_use_hit) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_flush_c = 1'b1;
        end
      end
      MC_WAIT: begin
        if (ex_mc_done) begin
          state_d = IDLE;
          wdog_d  = 8'd0;
        end else begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_stall_c = 1'b1;
          ex_wb_flush_c = 1'b1;
          if (wdog_q == WDOG_LAST) begin
            state_d      = MC_ABORT;
            mc_timeout_d = 1'b1;
          end else begin
            wdog_d = wdog_q + 8'd1;
          end
        end
      end
      MC_ABORT: begin
        pc_stall_c    = 1'b1;
        id_ex_flush_c = 1'b1;
        ex_wb_flush_c = 1'b1;
        flush_inc     = 1'b1;
        state_d       = IDLE;
        wdog_d        = 8'd0;
      end
      default: begin
        state_d = IDLE;
        wdog_d  = 8'd0;
      end
    endcase
  end

  // Saturating perf counters: stalled PC cycles and redirect/abort events.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (pc_stall_c && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 32'd1;
    if (flush_inc && (flush_events_q != '1))
      flush_events_d = flush_events_q + 16'd1;
  end

  // State, watchdog, pulse and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      wdog_q         <= 8'd0;
      mc_timeout_q   <= 1'b0;
      protocol_err_q <= 1'b0;
      stall_cycles_q <= 32'd0;
      flush_events_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      wdog_q         <= wdog_d;
      mc_timeout_q   <= mc_timeout_d;
      protocol_err_q <= protocol_err_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  // All outputs are held low for the whole time rst is asserted.
  assign pc_stall     = pc_stall_c    & ~rst;
  assign if_id_stall  = if_id_stall_c & ~rst;
  assign id_ex_stall  = id_ex_stall_c & ~rst;
  assign ex_wb_stall  = 1'b0;
  assign if_id_flush  = if_id_flush_c & ~rst;
  assign id_ex_flush  = id_ex_flush_c & ~rst;
  assign ex_wb_flush  = ex_wb_flush_c & ~rst;
  assign mc_timeout   = mc_timeout_q   & ~rst;
  assign protocol_err = protocol_err_q & ~rst;
  assign stall_cycles = rst ? 32'd0 : stall_cycles_q;
  assign flush_events = rst ? 16'd0 : flush_events_q;

endmodule
